// File: rtl/simon_pkg.sv
// Shared constants and types for the Simon 128/128 round controller.
// Z2 is written first-bit-first, so SIMON_Z2[i] is the i-th bit of the sequence.
package simon_pkg;

  localparam int SIMON_N      = 64;
  localparam int SIMON_ROUNDS = 68;

  localparam logic [SIMON_N-1:0] SIMON_C = 64'hFFFF_FFFF_FFFF_FFFC;

  localparam logic [0:61] SIMON_Z2 =
    62'b10101111011100000011010010011000101000010001111110010110110011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } simon_state_e;

  typedef struct packed {
    logic [SIMON_N-1:0] x;
    logic [SIMON_N-1:0] y;
  } simon_block_t;

  // The sequence has period 62; rounds 62..67 reuse its first six bits.
  function automatic logic z2_bit(input logic [6:0] i);
    logic [6:0] j;
    j = (i >= 7'd62) ? (i - 7'd62) : i;
    return SIMON_Z2[j[5:0]];
  endfunction

endpackage

// File: rtl/simon_round.sv
// One Simon 128/128 round plus one step of the two-word key schedule.
// Purely combinational; the controller registers every output.
module simon_round
  import simon_pkg::*;
(
  input  logic [SIMON_N-1:0] x,
  input  logic [SIMON_N-1:0] y,
  input  logic [SIMON_N-1:0] ka,
  input  logic [SIMON_N-1:0] kb,
  input  logic               z_bit,
  output logic [SIMON_N-1:0] x_next,
  output logic [SIMON_N-1:0] y_next,
  output logic [SIMON_N-1:0] ka_next,
  output logic [SIMON_N-1:0] kb_next
);

  logic [SIMON_N-1:0] x_rol1;
  logic [SIMON_N-1:0] x_rol2;
  logic [SIMON_N-1:0] x_rol8;
  logic [SIMON_N-1:0] kb_ror3;
  logic [SIMON_N-1:0] kb_ror4;

  assign x_rol1  = {x[62:0], x[63]};
  assign x_rol2  = {x[61:0], x[63:62]};
  assign x_rol8  = {x[55:0], x[63:56]};
  assign kb_ror3 = {kb[2:0], kb[63:3]};
  assign kb_ror4 = {kb[3:0], kb[63:4]};

  assign x_next  = y ^ (x_rol1 & x_rol8) ^ x_rol2 ^ ka;
  assign y_next  = x;
  assign ka_next = kb;
  // C already folds in the bitwise inversion of ka and the constant 3.
  assign kb_next = SIMON_C ^ {{(SIMON_N-1){1'b0}}, z_bit} ^ ka ^ kb_ror3 ^ kb_ror4;

endmodule

// File: rtl/simon_round_ctrl.sv
// Simon 128/128 block sequencer: key/plaintext intake, 68 rounds at one per cycle,
// ciphertext return. All handshakes are valid/ready: a transfer happens on the
// rising edge where both are high; valid never waits on ready, and once raised
// m_tvalid and m_tdata hold until that transfer.
module simon_round_ctrl
  import simon_pkg::*;
#(
  parameter int ROUNDS = SIMON_ROUNDS,
  parameter int CNT_W  = 32
)
(
  input  logic             simon_data_clk,
  input  logic             simon_data_rstn,
  input  logic [127:0]     key_data,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [127:0]     s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [127:0]     m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             busy,
  output logic             key_loaded,
  output logic [CNT_W-1:0] blocks_done,
  output logic [1:0]       dbg_state
);

  localparam int RND_W = 7;

  simon_state_e       state;
  logic [RND_W-1:0]   rnd;
  simon_block_t       blk;
  logic [SIMON_N-1:0] ka;
  logic [SIMON_N-1:0] kb;
  logic [SIMON_N-1:0] key_k0;
  logic [SIMON_N-1:0] key_k1;

  logic [SIMON_N-1:0] x_next;
  logic [SIMON_N-1:0] y_next;
  logic [SIMON_N-1:0] ka_next;
  logic [SIMON_N-1:0] kb_next;

  logic accept;
  logic key_take;
  logic last_round;

  assign key_ready  = (state == IDLE);
  assign s_tready   = key_loaded & ((state == IDLE) | ((state == DONE) & m_tready));
  assign accept     = s_tvalid & s_tready;
  assign key_take   = key_valid & key_ready;
  assign busy       = (state != IDLE);
  assign dbg_state  = state;
  assign last_round = (rnd == RND_W'(ROUNDS - 1));

  simon_round u_round (
    .x       (blk.x),
    .y       (blk.y),
    .ka      (ka),
    .kb      (kb),
    .z_bit   (z2_bit(rnd)),
    .x_next  (x_next),
    .y_next  (y_next),
    .ka_next (ka_next),
    .kb_next (kb_next)
  );

  always_ff @(posedge simon_data_clk) begin
    if (!simon_data_rstn) begin
      state       <= IDLE;
      rnd         <= '0;
      blk         <= '0;
      ka          <= '0;
      kb          <= '0;
      key_k0      <= '0;
      key_k1      <= '0;
      key_loaded  <= 1'b0;
      m_tvalid    <= 1'b0;
      m_tdata     <= '0;
      blocks_done <= '0;
    end else begin
      // A block accepted alongside a key update still reads the old key registers.
      if (key_take) begin
        key_k0     <= key_data[63:0];
        key_k1     <= key_data[127:64];
        key_loaded <= 1'b1;
      end

      if (m_tvalid && m_tready) begin
        blocks_done <= blocks_done + CNT_W'(1);
      end

      case (state)
        RUN: begin
          blk.x <= x_next;
          blk.y <= y_next;
          ka    <= ka_next;
          kb    <= kb_next;
          rnd   <= rnd + RND_W'(1);
          if (last_round) begin
            state    <= DONE;
            m_tvalid <= 1'b1;
            m_tdata  <= {x_next, y_next};
          end
        end
        DONE: begin
          if (m_tready) begin
            m_tvalid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
        end
      endcase

      // Accept is only possible from IDLE or from DONE while the output drains.
      if (accept) begin
        blk.x <= s_tdata[127:64];
        blk.y <= s_tdata[63:0];
        ka    <= key_k0;
        kb    <= key_k1;
        rnd   <= '0;
        state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Directed bench for simon_round_ctrl, built with a 4-bit block counter so the
// wrap-around is reachable in a short run.
module tb_simon_round_ctrl;

  localparam int CNT_W = 4;

  localparam logic [127:0] KEY0 = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] PT0  = 128'h63736564_20737265_6c6c6576_61727420;
  localparam logic [127:0] CT0  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;
  localparam logic [127:0] KEY1 = 128'h1122334455667788_99aabbccddeeff00;

  logic             clk = 1'b0;
  logic             rstn;
  logic [127:0]     key_data;
  logic             key_valid;
  logic             key_ready;
  logic [127:0]     s_tdata;
  logic             s_tvalid;
  logic             s_tready;
  logic [127:0]     m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             busy;
  logic             key_loaded;
  logic [CNT_W-1:0] blocks_done;
  logic [1:0]       dbg_state;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  simon_round_ctrl #(.ROUNDS(68), .CNT_W(CNT_W)) dut (
    .simon_data_clk  (clk),
    .simon_data_rstn (rstn),
    .key_data        (key_data),
    .key_valid       (key_valid),
    .key_ready       (key_ready),
    .s_tdata         (s_tdata),
    .s_tvalid        (s_tvalid),
    .s_tready        (s_tready),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .busy            (busy),
    .key_loaded      (key_loaded),
    .blocks_done     (blocks_done),
    .dbg_state       (dbg_state)
  );

  // Independent reference: full key schedule first, then the 68 rounds.
  function automatic logic [127:0] simon_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [63:0] k [0:67];
    logic [63:0] z;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] t;
    z = 64'h7369f885192c0ef5;
    k[0] = key[63:0];
    k[1] = key[127:64];
    for (int i = 0; i < 66; i++) begin
      t = (k[i+1] >> 3) | (k[i+1] << 61);
      t = t ^ ((t >> 1) | (t << 63));
      k[i+2] = ~k[i] ^ 64'd3 ^ {63'd0, z[i % 62]} ^ t;
    end
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < 68; i++) begin
      t = x;
      x = y ^ (((x << 1) | (x >> 63)) & ((x << 8) | (x >> 56))) ^ ((x << 2) | (x >> 62)) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Offers pt and returns just after the accepting edge; times out after 200 cycles.
  task automatic offer_block(input logic [127:0] pt);
    int n;
    n = 0;
    s_tdata  = pt;
    s_tvalid = 1'b1;
    #1;
    while (!s_tready && n < 200) begin
      step();
      n++;
    end
    vectors++;
    if (s_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_timeout: s_tready=%b expected 1", s_tready);
    end
    step();
    s_tvalid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!m_tvalid && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; key_valid = 1'b0; key_data = '0;
    s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
    step(); step();
    vectors++;
    if ({busy, key_loaded, m_tvalid, s_tready, key_ready} !== 5'b00001) begin
      miscompares++;
      $display("FAIL reset_flags: busy/kl/mv/sr/kr=%b expected 00001",
               {busy, key_loaded, m_tvalid, s_tready, key_ready});
    end
    vectors++;
    if (m_tdata !== 128'd0 || blocks_done !== '0) begin
      miscompares++;
      $display("FAIL reset_data: m_tdata=%h blocks_done=%0d expected 0/0", m_tdata, blocks_done);
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_no_key_then_basic();
    int bad;
    int lat;
    bad = 0;
    s_tdata  = PT0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (s_tready !== 1'b0 || busy !== 1'b0 || m_tvalid !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL no_key_idle: %0d bad cycles, expected 0", bad);
    end
    key_data  = KEY0;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    #1;
    vectors++;
    if (key_loaded !== 1'b1 || s_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL key_load: key_loaded=%b s_tready=%b expected 1/1", key_loaded, s_tready);
    end
    step();
    s_tvalid = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_busy: busy=%b expected 1", busy);
    end
    wait_out(lat);
    vectors++;
    if (lat != 68) begin
      miscompares++;
      $display("FAIL latency: %0d cycles expected 68", lat);
    end
    vectors++;
    if (m_tdata !== CT0) begin
      miscompares++;
      $display("FAIL basic_ct: m_tdata=%h expected %h", m_tdata, CT0);
    end
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    vectors++;
    if (m_tvalid !== 1'b0 || blocks_done !== 4'd1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drain: m_tvalid=%b blocks_done=%0d busy=%b expected 0/1/0",
               m_tvalid, blocks_done, busy);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    int lat;
    bad = 0;
    offer_block(PT0);
    wait_out(lat);
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_tvalid !== 1'b1 || m_tdata !== CT0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL stall_hold: %0d unstable cycles, expected 0", bad);
    end
    s_tdata  = PT0;
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    #1;
    vectors++;
    if (s_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready: s_tready=%b expected 1", s_tready);
    end
    step();
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    vectors++;
    if (m_tvalid !== 1'b0 || busy !== 1'b1 || blocks_done !== 4'd2) begin
      miscompares++;
      $display("FAIL b2b_accept: m_tvalid=%b busy=%b blocks_done=%0d expected 0/1/2",
               m_tvalid, busy, blocks_done);
    end
    wait_out(lat);
    vectors++;
    if (lat != 68 || m_tdata !== CT0) begin
      miscompares++;
      $display("FAIL b2b_result: lat=%0d m_tdata=%h expected 68/%h", lat, m_tdata, CT0);
    end
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
  endtask

  task automatic test_key_during_run();
    int lat;
    logic [127:0] exp_ct;
    offer_block(PT0);
    step(); step(); step();
    key_data  = KEY1;
    key_valid = 1'b1;
    #1;
    vectors++;
    if (key_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL key_ready_run: key_ready=%b expected 0", key_ready);
    end
    wait_out(lat);
    vectors++;
    if (m_tdata !== CT0 || key_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL old_key_ct: m_tdata=%h key_ready=%b expected %h/0", m_tdata, key_ready, CT0);
    end
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    #1;
    vectors++;
    if (key_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL key_ready_idle: key_ready=%b expected 1", key_ready);
    end
    step();
    key_valid = 1'b0;
    exp_ct = simon_ref(KEY1, PT0);
    offer_block(PT0);
    wait_out(lat);
    vectors++;
    if (m_tdata !== exp_ct) begin
      miscompares++;
      $display("FAIL new_key_ct: m_tdata=%h expected %h", m_tdata, exp_ct);
    end
    m_tready = 1'b1;
    step();
    m_tready = 1'b0;
    vectors++;
    if (blocks_done !== 4'd5) begin
      miscompares++;
      $display("FAIL count_5: blocks_done=%0d expected 5", blocks_done);
    end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    bad = 0;
    offer_block(PT0);
    for (int i = 0; i < 30; i++) step();
    rstn     = 1'b0;
    s_tdata  = PT0;
    s_tvalid = 1'b1;
    step();
    rstn = 1'b1;
    #1;
    vectors++;
    if ({busy, key_loaded, m_tvalid, s_tready} !== 4'b0000 || m_tdata !== 128'd0 ||
        blocks_done !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: busy/kl/mv/sr=%b m_tdata=%h blocks_done=%0d expected 0000/0/0",
               {busy, key_loaded, m_tvalid, s_tready}, m_tdata, blocks_done);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (s_tready !== 1'b0 || busy !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL post_reset_nokey: %0d bad cycles, expected 0", bad);
    end
    s_tvalid  = 1'b0;
    key_data  = KEY0;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  task automatic test_wrap();
    int done;
    int t;
    int t_prev;
    int bad_data;
    int bad_cnt;
    int bad_gap;
    done = 0; t = 0; t_prev = -1;
    bad_data = 0; bad_cnt = 0; bad_gap = 0;
    s_tdata  = PT0;
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    while (done < 16 && t < 3000) begin
      step();
      t++;
      if (m_tvalid) begin
        if (m_tdata !== CT0) bad_data++;
        if (t_prev >= 0 && (t - t_prev) != 69) bad_gap++;
        t_prev = t;
        step();
        t++;
        done++;
        if (blocks_done !== CNT_W'(done)) bad_cnt++;
        if (done == 15 && blocks_done !== 4'hF) bad_cnt++;
      end
    end
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    vectors++;
    if (done != 16) begin
      miscompares++;
      $display("FAIL wrap_timeout: %0d blocks completed, expected 16", done);
    end
    vectors++;
    if (bad_data != 0 || bad_gap != 0) begin
      miscompares++;
      $display("FAIL stream: %0d bad ciphertexts, %0d bad gaps, expected 0/0", bad_data, bad_gap);
    end
    vectors++;
    if (bad_cnt != 0) begin
      miscompares++;
      $display("FAIL count_track: %0d bad counts, expected 0", bad_cnt);
    end
    vectors++;
    if (blocks_done !== 4'd0) begin
      miscompares++;
      $display("FAIL wrap: blocks_done=%0d expected 0", blocks_done);
    end
  endtask

  initial begin
    test_reset();
    test_no_key_then_basic();
    test_back_to_back();
    test_key_during_run();
    test_reset_mid_run();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
